// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: samples a pre-synchronized serial line and emits bytes with a
// one-clock ready strobe, rejecting start glitches and flagging bad stop bits.
module uart_rx_framer #(
   parameter int CLKS_PER_BIT = 434,
   parameter int CNT_W        = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   output logic       frame_err,
   output logic       busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_rdy_q, rx_rdy_d;
   logic             frame_err_q, frame_err_d;
   logic             armed_q, armed_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         baud_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         rx_data_q   <= '0;
         rx_rdy_q    <= 1'b0;
         frame_err_q <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         rx_data_q   <= rx_data_d;
         rx_rdy_q    <= rx_rdy_d;
         frame_err_q <= frame_err_d;
         armed_q     <= armed_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      rx_data_d   = rx_data_q;
      rx_rdy_d    = 1'b0;
      frame_err_d = 1'b0;
      armed_d     = armed_q;
      case (state_q)
         IDLE: begin
            // A falling edge only counts once the line has been seen idle-high,
            // so a held-low line (break, mid-frame reset release) cannot start a frame.
            if (armed_q && !rx) begin
               state_d    = START;
               baud_cnt_d = '0;
               armed_d    = 1'b0;
            end else if (rx) begin
               armed_d = 1'b1;
            end
         end
         START: begin
            if (baud_cnt_q == HALF_M1) begin
               baud_cnt_d = '0;
               if (rx) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_ONE;
            end
         end
         DATA: begin
            if (baud_cnt_q == BIT_M1) begin
               baud_cnt_d = '0;
               shreg_d    = {rx, shreg_q[7:1]};
               bit_idx_d  = bit_idx_q + 4'd1;
               if (bit_idx_q == 4'd7) begin
                  state_d = STOP;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_ONE;
            end
         end
         STOP: begin
            // Sampling mid-stop leaves half a bit of idle line to re-arm.
            if (baud_cnt_q == BIT_M1) begin
               baud_cnt_d = '0;
               state_d    = IDLE;
               if (rx) begin
                  rx_data_d = shreg_q;
                  rx_rdy_d  = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d    = IDLE;
            baud_cnt_d = '0;
         end
      endcase
   end

   assign rx_data   = rx_data_q;
   assign rx_rdy    = rx_rdy_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule
